// File: rtl/cnn_mac_pipe.sv
// +-----------------------------------------------------------------------------+
// | cnn_mac_pipe : pipelined signed MAC, one scaled dot product per in_last group |
// | Optional saturation of dout (sets ovf) when CNN_MAC_SAT_EN is defined.        |
// | Revision: 1.0                                                                 |
// +-----------------------------------------------------------------------------+
`default_nettype none

module cnn_mac_pipe #(
  parameter int A_W       = 14,
  parameter int B_W       = 9,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 16,
  parameter int MUL_STAGE = 2,
  parameter int OUT_SHIFT = 8
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic signed [A_W-1:0]   din0,
  input  logic signed [B_W-1:0]   din1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  localparam int c_prod_w = A_W + B_W;

  logic                    adv;
  logic signed [A_W-1:0]   a_q, a_d;
  logic signed [B_W-1:0]   b_q, b_d;
  logic                    iv_q, iv_d;
  logic                    il_q, il_d;
  logic signed [c_prod_w-1:0] mul_full;
  logic signed [ACC_W-1:0] prod_q [MUL_STAGE];
  logic signed [ACC_W-1:0] prod_d [MUL_STAGE];
  logic [MUL_STAGE-1:0]    pv_q, pv_d;
  logic [MUL_STAGE-1:0]    pl_q, pl_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    start_q, start_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] dout_q, dout_d;
  logic                    ovf_q, ovf_d;
  logic signed [ACC_W-1:0] sum;
  logic signed [OUT_W-1:0] res;
  logic                    res_ovf;

  // Every stage, including the accumulator, moves only when the output slot can take data.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    iv_d     = iv_q;
    il_d     = il_q;
    prod_d   = prod_q;
    pv_d     = pv_q;
    pl_d     = pl_q;
    mul_full = c_prod_w'(a_q) * c_prod_w'(b_q);
    if (adv) begin
      a_d       = din0;
      b_d       = din1;
      iv_d      = in_valid;
      il_d      = in_last;
      prod_d[0] = ACC_W'(mul_full);
      pv_d[0]   = iv_q;
      pl_d[0]   = il_q;
      for (int k = 1; k < MUL_STAGE; k++) begin
        prod_d[k] = prod_q[k-1];
        pv_d[k]   = pv_q[k-1];
        pl_d[k]   = pl_q[k-1];
      end
    end
  end

`ifdef CNN_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = sum >>> OUT_SHIFT;
    res     = shifted[OUT_W-1:0];
    res_ovf = 1'b0;
    if (shifted > c_sat_max) begin
      res     = c_sat_max[OUT_W-1:0];
      res_ovf = 1'b1;
    end else if (shifted < c_sat_min) begin
      res     = c_sat_min[OUT_W-1:0];
      res_ovf = 1'b1;
    end
  end
`else
  always_comb begin
    res     = OUT_W'(sum >>> OUT_SHIFT);
    res_ovf = 1'b0;
  end
`endif

  always_comb begin
    sum         = (start_q ? '0 : acc_q) + prod_q[MUL_STAGE-1];
    acc_d       = acc_q;
    start_d     = start_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    if (adv && pv_q[MUL_STAGE-1]) begin
      acc_d   = sum;
      start_d = pl_q[MUL_STAGE-1];
    end
    if (adv && pv_q[MUL_STAGE-1] && pl_q[MUL_STAGE-1]) begin
      out_valid_d = 1'b1;
      dout_d      = res;
      ovf_d       = res_ovf;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      iv_q <= 1'b0;
      il_q <= 1'b0;
      for (int k = 0; k < MUL_STAGE; k++) begin
        prod_q[k] <= '0;
      end
      pv_q        <= '0;
      pl_q        <= '0;
      acc_q       <= '0;
      start_q     <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      iv_q        <= iv_d;
      il_q        <= il_d;
      prod_q      <= prod_d;
      pv_q        <= pv_d;
      pl_q        <= pl_d;
      acc_q       <= acc_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire
